// File: rtl/prog_seq_pkg.sv
// Shared types for the program sequencer: PC commands, FSM states,
// and the default table of program start addresses.
package prog_seq_pkg;

    localparam int MAX_NPROG = 8;

    typedef enum logic [2:0] {
        INC    = 3'd0,
        HOLD   = 3'd1,
        BR_REL = 3'd2,
        BR_ABS = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5
    } pc_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        HALTED   = 3'd2,
        FAULT    = 3'd3,
        FINISHED = 3'd4
    } seq_state_t;

    // Index 0 is the rightmost entry.
    typedef logic [MAX_NPROG-1:0][31:0] base_tbl_t;

    localparam base_tbl_t DEF_BASE = {
        32'd0, 32'd0, 32'd0, 32'd0,
        32'd0, 32'd400, 32'd160, 32'd0
    };

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: LIFO of SDEPTH addresses with synchronous
// push/pop/clear; overflow and underflow are refused, not wrapped.
module ret_stack #(
    parameter int A      = 10,
    parameter int SDEPTH = 4,
    localparam int DW    = $clog2(SDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [A-1:0]  push_data,
    output logic [A-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [A-1:0]  mem_q [SDEPTH];
    logic [A-1:0]  mem_d [SDEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    assign full  = (depth_q == DW'(SDEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        top     = '0;
        for (int i = 0; i < SDEPTH; i++) begin
            if (DW'(i) == depth_q - DW'(1)) top = mem_q[i];
        end
        if (clear) begin
            depth_d = '0;
        end else if (push && !full) begin
            for (int i = 0; i < SDEPTH; i++) begin
                if (DW'(i) == depth_q) mem_d[i] = push_data;
            end
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < SDEPTH; i++) mem_q[i] <= '0;
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: launches a series of programs on Start edges and
// steps the program counter with branch, call and return commands.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int        A         = 10,
    parameter int        NPROG     = 3,
    parameter int        SDEPTH    = 4,
    parameter int        OFFW      = 8,
    parameter base_tbl_t PROG_BASE = DEF_BASE,
    localparam int       DW        = $clog2(SDEPTH + 1)
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic            Start,
    input  logic [2:0]      PcOp,
    input  logic            Cond,
    input  logic [OFFW-1:0] Offset,
    input  logic            Halt,
    output logic [A-1:0]    ProgCtr,
    output logic [2:0]      ProgIdx,
    output logic            Running,
    output logic            Done,
    output logic            Fault,
    output logic            Finished,
    output logic [DW-1:0]   StackDepth
);

    localparam logic [3:0] NP = 4'(NPROG);

    seq_state_t    state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic [3:0]    idx_q, idx_d;
    logic          start_q;
    logic          armed_q;
    logic          running_q, done_q, fault_q, finished_q;

    logic          rise, fall;
    logic [A-1:0]  base, stk_top;
    logic          push, pop, clr;
    logic          stk_full, stk_empty;

    ret_stack #(.A(A), .SDEPTH(SDEPTH)) u_stack (
        .clk       (Clk),
        .rst_n     (ResetN),
        .push      (push),
        .pop       (pop),
        .clear     (clr),
        .push_data (pc_q + A'(1)),
        .top       (stk_top),
        .depth     (StackDepth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // armed_q masks the first cycle after reset, when start_q is still
    // at its reset value and a held-high Start would look like an edge.
    assign rise = Start & ~start_q & armed_q;
    assign fall = ~Start & start_q & armed_q;

    always_comb begin
        base = '0;
        for (int i = 0; i < MAX_NPROG; i++) begin
            if (idx_q == 4'(i + 1)) base = PROG_BASE[i][A-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        idx_d   = (rise && idx_q < NP) ? idx_q + 4'd1 : idx_q;
        if (fall && idx_q != 4'd0) begin
            if (state_q == HALTED && idx_q == NP) begin
                state_d = FINISHED;
            end else begin
                pc_d    = base;
                clr     = 1'b1;
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (Halt) begin
                state_d = HALTED;
            end else begin
                case (PcOp)
                    INC:    pc_d = pc_q + A'(1);
                    BR_REL: pc_d = Cond ? pc_q + A'($signed(Offset))
                                        : pc_q + A'(1);
                    BR_ABS: pc_d = Cond ? base + A'(Offset)
                                        : pc_q + A'(1);
                    CALL: begin
                        if (stk_full) begin
                            state_d = FAULT;
                        end else begin
                            push = 1'b1;
                            pc_d = base + A'(Offset);
                        end
                    end
                    RET: begin
                        if (stk_empty) begin
                            state_d = FAULT;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stk_top;
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            idx_q      <= '0;
            start_q    <= 1'b0;
            armed_q    <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            start_q    <= Start;
            armed_q    <= 1'b1;
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == HALTED);
            fault_q    <= (state_d == FAULT);
            finished_q <= (state_d == FINISHED);
        end
    end

    assign ProgCtr  = pc_q;
    assign ProgIdx  = idx_q[2:0];
    assign Running  = running_q;
    assign Done     = done_q;
    assign Fault    = fault_q;
    assign Finished = finished_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: default instance plus a 4-bit
// address instance used for the wrap-around case.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    logic        Clk, ResetN, Start, Cond, Halt;
    logic [2:0]  PcOp;
    logic [7:0]  Offset;
    logic [9:0]  ProgCtr;
    logic [2:0]  ProgIdx, StackDepth;
    logic        Running, Done, Fault, Finished;

    logic        start2;
    logic [2:0]  op2;
    logic [3:0]  pc2;
    logic [2:0]  idx2, sd2;
    logic        run2, done2, fault2, fin2;

    int checks;
    int errors;

    prog_sequencer dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start), .PcOp(PcOp),
        .Cond(Cond), .Offset(Offset), .Halt(Halt),
        .ProgCtr(ProgCtr), .ProgIdx(ProgIdx), .Running(Running),
        .Done(Done), .Fault(Fault), .Finished(Finished),
        .StackDepth(StackDepth)
    );

    prog_sequencer #(.A(4), .OFFW(4)) dut4 (
        .Clk(Clk), .ResetN(ResetN), .Start(start2), .PcOp(op2),
        .Cond(1'b0), .Offset(4'd0), .Halt(1'b0),
        .ProgCtr(pc2), .ProgIdx(idx2), .Running(run2),
        .Done(done2), .Fault(fault2), .Finished(fin2),
        .StackDepth(sd2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic pulse();
        PcOp  = HOLD;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ResetN = 1'b0;
        Start  = 1'b0;
        Cond   = 1'b0;
        Halt   = 1'b0;
        PcOp   = HOLD;
        Offset = 8'd0;
        start2 = 1'b0;
        op2    = HOLD;
        #1;
        chk("rst_pc", 32'(ProgCtr), 0);
        chk("rst_idx", 32'(ProgIdx), 0);
        chk("rst_depth", 32'(StackDepth), 0);
        chk("rst_flags", {28'd0, Running, Done, Fault, Finished}, 0);
        @(negedge Clk);
        ResetN = 1'b1;
        cyc(2);

        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        chk("a4_run", 32'(run2), 1);
        op2 = INC;
        cyc(15);
        chk("a4_pc15", 32'(pc2), 15);
        step();
        chk("a4_wrap", 32'(pc2), 0);
        op2 = HOLD;

        pulse();
        chk("p1_idx", 32'(ProgIdx), 1);
        chk("p1_pc", 32'(ProgCtr), 0);
        chk("p1_run", 32'(Running), 1);
        PcOp = INC;
        cyc(5);
        chk("inc5", 32'(ProgCtr), 5);
        cyc(2);
        PcOp   = CALL;
        Offset = 8'd30;
        step();
        chk("call_pc", 32'(ProgCtr), 30);
        chk("call_depth", 32'(StackDepth), 1);
        PcOp = RET;
        step();
        chk("ret_pc", 32'(ProgCtr), 8);
        chk("ret_depth", 32'(StackDepth), 0);

        PcOp = CALL;
        cyc(4);
        chk("call4_depth", 32'(StackDepth), 4);
        step();
        chk("ovf_fault", 32'(Fault), 1);
        chk("ovf_pc", 32'(ProgCtr), 30);
        chk("ovf_depth", 32'(StackDepth), 4);
        chk("ovf_run", 32'(Running), 0);
        PcOp = INC;
        step();
        chk("fault_hold", 32'(ProgCtr), 30);

        pulse();
        chk("p2_idx", 32'(ProgIdx), 2);
        chk("p2_pc", 32'(ProgCtr), 160);
        chk("p2_fault", 32'(Fault), 0);
        chk("p2_depth", 32'(StackDepth), 0);
        PcOp   = BR_REL;
        Cond   = 1'b1;
        Offset = 8'hFE;
        step();
        chk("brrel_t", 32'(ProgCtr), 158);
        Cond = 1'b0;
        step();
        chk("brrel_f", 32'(ProgCtr), 159);
        PcOp = RET;
        step();
        chk("udf_fault", 32'(Fault), 1);
        chk("udf_pc", 32'(ProgCtr), 159);

        pulse();
        chk("p3_pc", 32'(ProgCtr), 400);
        PcOp   = BR_ABS;
        Cond   = 1'b1;
        Offset = 8'd20;
        step();
        chk("brabs_t", 32'(ProgCtr), 420);
        Cond = 1'b0;
        step();
        chk("brabs_f", 32'(ProgCtr), 421);
        PcOp = 3'd7;
        step();
        chk("undef_op", 32'(ProgCtr), 421);
        PcOp   = BR_REL;
        Cond   = 1'b1;
        Offset = 8'd5;
        Halt   = 1'b1;
        step();
        chk("halt_done", 32'(Done), 1);
        chk("halt_pc", 32'(ProgCtr), 421);
        chk("halt_run", 32'(Running), 0);
        Halt = 1'b0;
        pulse();
        chk("fin_flag", 32'(Finished), 1);
        chk("fin_idx", 32'(ProgIdx), 3);
        chk("fin_pc", 32'(ProgCtr), 421);
        chk("fin_done", 32'(Done), 0);

        ResetN = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        cyc(2);
        pulse();
        chk("re_p1_pc", 32'(ProgCtr), 0);
        PcOp = INC;
        cyc(2);
        PcOp  = HOLD;
        Start = 1'b1;
        step();
        Start = 1'b0;
        Halt  = 1'b1;
        PcOp  = INC;
        step();
        chk("prio_run", 32'(Running), 1);
        chk("prio_pc", 32'(ProgCtr), 160);
        Halt = 1'b0;
        cyc(2);
        chk("prio_inc", 32'(ProgCtr), 162);
        PcOp   = CALL;
        Offset = 8'd3;
        step();
        chk("pre_rst_depth", 32'(StackDepth), 1);
        chk("pre_rst_pc", 32'(ProgCtr), 163);
        #2;
        ResetN = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(ProgCtr), 0);
        chk("mid_rst_idx", 32'(ProgIdx), 0);
        chk("mid_rst_depth", 32'(StackDepth), 0);
        chk("mid_rst_flags", {28'd0, Running, Done, Fault, Finished}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
